// File: rtl/mac_tx_interface.sv
// mac_tx_interface
// Drains packets (one header word followed by its data words) from the
// 512-entry TX buffer into the 64-bit 10G MAC Tx client interface. Each
// packet is streamed without gaps once the MAC acknowledges the start of the
// frame. The block hands back a committed read pointer so the 250 MHz host
// side can reclaim buffer space. Only packets the host has already committed
// are read, so the MAC never sees an underrun.
module mac_tx_interface #(
   parameter int MAX_FRAME_BYTES = 1518
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [63:0] tx_data,
   output logic [7:0]  tx_data_valid,
   output logic        tx_start,
   input  logic        tx_ack,
   output logic        tx_underrun,
   output logic [8:0]  rd_addr,
   input  logic [63:0] rd_data,
   input  logic [9:0]  commited_wr_address,
   output logic [9:0]  commited_rd_address,
   output logic [31:0] frames_sent_counter,
   output logic [31:0] bad_desc_counter
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_HDR    = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_COMMIT = 3'd4;

   // START is split into three phases because the buffer read has one cycle
   // of latency: LOAD captures word 1 into the output register, FIRST is the
   // first cycle tx_start is visible (word 2 is on rd_data), WAIT covers any
   // further cycles until the MAC acknowledges (word 2 held in nxt_word).
   localparam logic [1:0] PH_LOAD  = 2'd0;
   localparam logic [1:0] PH_FIRST = 2'd1;
   localparam logic [1:0] PH_WAIT  = 2'd2;

   logic [2:0]  state;
   logic [1:0]  phase;

   logic [9:0]  wr_reg0;
   logic [9:0]  wr_reg1;
   logic [9:0]  wr_sync;

   // rd_ptr is the extended read pointer driving the buffer address. It runs
   // ahead of the word on tx_data so that one word per cycle can be presented.
   logic [9:0]  rd_ptr;
   logic [9:0]  next_hdr;
   logic [7:0]  words_total;
   logic [7:0]  words_left;
   logic [7:0]  last_mask;
   logic [63:0] nxt_word;

   logic [31:0] hdr_len;
   logic        hdr_bad;
   logic [7:0]  hdr_words;
   logic [7:0]  hdr_mask;

   // Byte-valid mask of the final word of a frame from len mod 8.
   function automatic logic [7:0] tail_mask(input logic [2:0] rem);
      logic [15:0] ones;
      ones = (16'd1 << rem) - 16'd1;
      if (rem == 3'd0) begin
         return 8'hFF;
      end
      return ones[7:0];
   endfunction

   assign rd_addr     = rd_ptr[8:0];
   assign tx_underrun = 1'b0;

   // Decode the header word currently returned by the buffer. Only the low
   // 11 bits of len matter once the corrupt-length check has passed.
   always_comb begin
      hdr_len   = rd_data[63:32];
      hdr_bad   = hdr_len > 32'(MAX_FRAME_BYTES);
      hdr_words = 8'((hdr_len[10:0] + 11'd7) >> 3);
      hdr_mask  = tail_mask(hdr_len[2:0]);
   end

   // Two-stage capture of the host write pointer; the filtered copy only
   // follows when both stages agree, so a multi-bit change caught mid-flight
   // is never used.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_reg0 <= '0;
         wr_reg1 <= '0;
         wr_sync <= '0;
      end else begin
         wr_reg0 <= commited_wr_address;
         wr_reg1 <= wr_reg0;
         if (wr_reg0 == wr_reg1) begin
            wr_sync <= wr_reg1;
         end
      end
   end

   // Frame sequencer: header fetch and decode, start handshake with the MAC,
   // gap-free data streaming and commit of the read pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state               <= ST_IDLE;
         phase               <= PH_LOAD;
         rd_ptr              <= '0;
         next_hdr            <= '0;
         words_total         <= '0;
         words_left          <= '0;
         last_mask           <= '0;
         nxt_word            <= '0;
         tx_data             <= '0;
         tx_data_valid       <= '0;
         tx_start            <= 1'b0;
         commited_rd_address <= '0;
         frames_sent_counter <= '0;
         bad_desc_counter    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               tx_data       <= '0;
               tx_data_valid <= '0;
               tx_start      <= 1'b0;
               // rd_addr already points at the header; step ahead to word 1
               // so it is being read while the header is decoded.
               if (rd_ptr != wr_sync) begin
                  rd_ptr <= rd_ptr + 10'd1;
                  state  <= ST_HDR;
               end
            end

            ST_HDR: begin
               if (hdr_len == 32'd0) begin
                  // Empty packet: rd_ptr is already hdr + 1.
                  commited_rd_address <= rd_ptr;
                  state               <= ST_IDLE;
               end else if (hdr_bad) begin
                  // Nothing after a corrupt header can be trusted, so drop
                  // everything the host has committed so far.
                  rd_ptr              <= wr_sync;
                  commited_rd_address <= wr_sync;
                  bad_desc_counter    <= bad_desc_counter + 32'd1;
                  state               <= ST_IDLE;
               end else begin
                  rd_ptr      <= rd_ptr + 10'd1;
                  next_hdr    <= rd_ptr + {2'b00, hdr_words};
                  words_total <= hdr_words;
                  last_mask   <= hdr_mask;
                  phase       <= PH_LOAD;
                  state       <= ST_START;
               end
            end

            ST_START: begin
               case (phase)
                  PH_LOAD: begin
                     tx_data       <= rd_data;
                     tx_data_valid <= (words_total == 8'd1) ? last_mask : 8'hFF;
                     tx_start      <= 1'b1;
                     rd_ptr        <= rd_ptr + 10'd1;
                     phase         <= PH_FIRST;
                  end
                  default: begin
                     if (phase == PH_FIRST) begin
                        nxt_word <= rd_data;
                     end
                     if (tx_ack) begin
                        tx_start <= 1'b0;
                        if (words_total == 8'd1) begin
                           tx_data       <= '0;
                           tx_data_valid <= '0;
                           state         <= ST_COMMIT;
                        end else begin
                           tx_data       <= (phase == PH_FIRST) ? rd_data : nxt_word;
                           tx_data_valid <= (words_total == 8'd2) ? last_mask : 8'hFF;
                           words_left    <= words_total - 8'd2;
                           rd_ptr        <= rd_ptr + 10'd1;
                           state         <= ST_DATA;
                        end
                     end else begin
                        phase <= PH_WAIT;
                     end
                  end
               endcase
            end

            ST_DATA: begin
               if (words_left == 8'd0) begin
                  tx_data       <= '0;
                  tx_data_valid <= '0;
                  state         <= ST_COMMIT;
               end else begin
                  tx_data       <= rd_data;
                  tx_data_valid <= (words_left == 8'd1) ? last_mask : 8'hFF;
                  words_left    <= words_left - 8'd1;
                  rd_ptr        <= rd_ptr + 10'd1;
               end
            end

            ST_COMMIT: begin
               rd_ptr              <= next_hdr;
               commited_rd_address <= next_hdr;
               frames_sent_counter <= frames_sent_counter + 32'd1;
               state               <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_tx_interface.sv
// tb_mac_tx_interface
// Directed bench for mac_tx_interface. A buffer memory feeds the DUT; every
// packet written into it is also turned into an expected word/mask stream,
// which a monitor compares against the MAC-side outputs cycle by cycle while
// also playing the MAC's tx_ack role.
`timescale 1ns/1ps
module tb_mac_tx_interface;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] tx_data;
   logic [7:0]  tx_data_valid;
   logic        tx_start;
   logic        tx_ack = 1'b0;
   logic        tx_underrun;
   logic [8:0]  rd_addr;
   logic [63:0] rd_data = '0;
   logic [9:0]  commited_wr_address = '0;
   logic [9:0]  commited_rd_address;
   logic [31:0] frames_sent_counter;
   logic [31:0] bad_desc_counter;

   logic [63:0] mem [0:511];

   logic [63:0] exp_w[$];
   logic [7:0]  exp_m[$];
   int          exp_n[$];

   int tests_run = 0;
   int failures = 0;
   int frames_done = 0;
   int ack_hold = 1;
   int start_cycles = 0;
   int last_start_cycles = 0;
   int word_idx = 0;
   bit in_frame = 1'b0;

   mac_tx_interface #(.MAX_FRAME_BYTES(1518)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .tx_data             (tx_data),
      .tx_data_valid       (tx_data_valid),
      .tx_start            (tx_start),
      .tx_ack              (tx_ack),
      .tx_underrun         (tx_underrun),
      .rd_addr             (rd_addr),
      .rd_data             (rd_data),
      .commited_wr_address (commited_wr_address),
      .commited_rd_address (commited_rd_address),
      .frames_sent_counter (frames_sent_counter),
      .bad_desc_counter    (bad_desc_counter)
   );

   always #5 clk = ~clk;

   // Registered buffer read with one cycle of latency.
   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] last_mask_of(input int len);
      int r;
      r = len % 8;
      if (r == 0) return 8'hFF;
      return 8'((1 << r) - 1);
   endfunction

   function automatic logic [63:0] make_word(input int tag, input int idx);
      return {8'(8'hC0 + tag), 8'(idx), 16'hBEEF, 16'(tag * 256 + idx), 16'(idx * 3 + 1)};
   endfunction

   // Writes one packet at extended address hdr and records the frame the MAC
   // should receive; next_hdr is where the following header belongs.
   task automatic apply_stimulus(input int hdr, input int len, input int tag,
                                 output int next_hdr);
      int nw;
      nw = (len + 7) / 8;
      mem[hdr % 512] = {32'(len), 32'hDEAD_BEEF};
      next_hdr = -1;
      if (len >= 1 && len <= 1518) begin
         for (int i = 1; i <= nw; i++) begin
            mem[(hdr + i) % 512] = make_word(tag, i);
            exp_w.push_back(make_word(tag, i));
            exp_m.push_back((i == nw) ? last_mask_of(len) : 8'hFF);
         end
         exp_n.push_back(nw);
         next_hdr = (hdr + 1 + nw) % 1024;
      end else if (len == 0) begin
         next_hdr = (hdr + 1) % 1024;
      end
   endtask

   task automatic wait_frames(input int target, input int budget);
      int cycles;
      cycles = 0;
      while (frames_done < target && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check_output("frame_timeout", 64'(frames_done >= target), 64'd1);
   endtask

   // Monitor and MAC model: compares outputs every cycle and raises tx_ack
   // once tx_start has been seen for ack_hold cycles.
   initial begin
      forever begin
         @(negedge clk);
         tx_ack = 1'b0;
         if (!reset_n) begin
            check_output("reset_valid", 64'(tx_data_valid), 64'd0);
            check_output("reset_start", 64'(tx_start), 64'd0);
            check_output("reset_data", tx_data, 64'd0);
            in_frame = 1'b0;
            word_idx = 0;
            start_cycles = 0;
            exp_w.delete();
            exp_m.delete();
            exp_n.delete();
         end else begin
            check_output("underrun", 64'(tx_underrun), 64'd0);
            if (tx_start) begin
               if (in_frame || exp_n.size() == 0) begin
                  check_output("unexpected_start", 64'(tx_start), 64'd0);
               end else begin
                  start_cycles++;
                  check_output("start_data", tx_data, exp_w[0]);
                  check_output("start_valid", 64'(tx_data_valid), 64'(exp_m[0]));
                  if (start_cycles >= ack_hold) begin
                     tx_ack = 1'b1;
                     in_frame = 1'b1;
                     word_idx = 1;
                     last_start_cycles = start_cycles;
                     start_cycles = 0;
                  end
               end
            end else if (in_frame) begin
               if (word_idx < exp_n[0]) begin
                  check_output("stream_data", tx_data, exp_w[word_idx]);
                  check_output("stream_valid", 64'(tx_data_valid), 64'(exp_m[word_idx]));
                  word_idx++;
               end else begin
                  int n;
                  n = exp_n[0];
                  check_output("commit_gap_valid", 64'(tx_data_valid), 64'd0);
                  for (int i = 0; i < n; i++) begin
                     void'(exp_w.pop_front());
                     void'(exp_m.pop_front());
                  end
                  void'(exp_n.pop_front());
                  in_frame = 1'b0;
                  frames_done++;
               end
            end else begin
               check_output("idle_valid", 64'(tx_data_valid), 64'd0);
               check_output("idle_data", tx_data, 64'd0);
            end
         end
      end
   end

   // Directed scenarios.
   initial begin
      int nxt;
      int base;
      int cycles;
      for (int i = 0; i < 512; i++) mem[i] = {32'h0BAD_0000, 32'(i)};

      repeat (3) @(negedge clk);
      check_output("rst_commited_rd", 64'(commited_rd_address), 64'd0);
      check_output("rst_rd_addr", 64'(rd_addr), 64'd0);
      check_output("rst_frames", 64'(frames_sent_counter), 64'd0);
      check_output("rst_bad", 64'(bad_desc_counter), 64'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check_output("idle_rd_addr", 64'(rd_addr), 64'd0);

      check_output("model_mask_64", 64'(last_mask_of(64)), 64'h0FF);
      check_output("model_mask_61", 64'(last_mask_of(61)), 64'h01F);
      check_output("model_mask_60", 64'(last_mask_of(60)), 64'h00F);

      // 64-byte frame at header 0, immediate ack.
      ack_hold = 1;
      base = frames_done;
      apply_stimulus(0, 64, 1, nxt);
      check_output("model_next_s1", 64'(nxt), 64'd9);
      commited_wr_address = 10'(nxt);
      wait_frames(base + 1, 200);
      repeat (3) @(negedge clk);
      check_output("s1_commited_rd", 64'(commited_rd_address), 64'd9);
      check_output("s1_frames", 64'(frames_sent_counter), 64'd1);
      check_output("s1_start_cycles", 64'(last_start_cycles), 64'd1);

      // 61-byte frame, MAC holds off the ack for 5 cycles.
      ack_hold = 5;
      base = frames_done;
      apply_stimulus(9, 61, 2, nxt);
      commited_wr_address = 10'(nxt);
      wait_frames(base + 1, 200);
      repeat (3) @(negedge clk);
      check_output("s2_start_cycles", 64'(last_start_cycles), 64'd5);
      check_output("s2_commited_rd", 64'(commited_rd_address), 64'd18);
      check_output("s2_frames", 64'(frames_sent_counter), 64'd2);

      // Corrupt header flushes up to the synced write pointer.
      apply_stimulus(18, 2000, 3, nxt);
      commited_wr_address = 10'h3FC;
      repeat (30) @(negedge clk);
      check_output("bad_counter", 64'(bad_desc_counter), 64'd1);
      check_output("bad_commited_rd", 64'(commited_rd_address), 64'h3FC);
      check_output("bad_frames", 64'(frames_sent_counter), 64'd2);

      // Frame wrapping the buffer and the extended pointer.
      ack_hold = 2;
      base = frames_done;
      apply_stimulus(10'h3FC, 40, 4, nxt);
      check_output("model_next_wrap", 64'(nxt), 64'd2);
      commited_wr_address = 10'(nxt);
      wait_frames(base + 1, 200);
      repeat (3) @(negedge clk);
      check_output("wrap_commited_rd", 64'(commited_rd_address), 64'h002);
      check_output("wrap_frames", 64'(frames_sent_counter), 64'd3);

      // Zero-length header skipped, then a single-word frame.
      ack_hold = 1;
      base = frames_done;
      apply_stimulus(2, 0, 5, nxt);
      apply_stimulus(nxt, 8, 6, nxt);
      commited_wr_address = 10'(nxt);
      wait_frames(base + 1, 200);
      repeat (3) @(negedge clk);
      check_output("len0_commited_rd", 64'(commited_rd_address), 64'd5);
      check_output("len0_frames", 64'(frames_sent_counter), 64'd4);
      check_output("len0_bad", 64'(bad_desc_counter), 64'd1);

      // Reset in the middle of the data phase.
      apply_stimulus(5, 64, 7, nxt);
      commited_wr_address = 10'(nxt);
      cycles = 0;
      while (!(in_frame && word_idx >= 4) && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      check_output("mid_frame_reached", 64'(in_frame && word_idx >= 4), 64'd1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_output("abort_valid", 64'(tx_data_valid), 64'd0);
      check_output("abort_rd_addr", 64'(rd_addr), 64'd0);
      check_output("abort_commited_rd", 64'(commited_rd_address), 64'd0);
      check_output("abort_frames", 64'(frames_sent_counter), 64'd0);
      check_output("abort_bad", 64'(bad_desc_counter), 64'd0);
      commited_wr_address = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check_output("post_rst_commited_rd", 64'(commited_rd_address), 64'd0);
      check_output("post_rst_frames", 64'(frames_sent_counter), 64'd0);

      base = frames_done;
      apply_stimulus(0, 16, 8, nxt);
      commited_wr_address = 10'(nxt);
      wait_frames(base + 1, 200);
      repeat (3) @(negedge clk);
      check_output("restart_commited_rd", 64'(commited_rd_address), 64'd3);
      check_output("restart_frames", 64'(frames_sent_counter), 64'd1);
      check_output("model_drained", 64'(exp_n.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule

// File: doc/mac_tx_interface.md
Name: mac_tx_interface

Overview:
Transmit-side counterpart of the MAC Rx buffer path. Reads packets that the 250 MHz host-side engine has placed in a 512-word internal TX buffer and streams them into the 10G MAC Tx client interface (64-bit, per-byte valid). Each packet in the buffer is a header word followed by its data words. The block returns a committed read pointer so the host side can reclaim space.

Parameters:
MAX_FRAME_BYTES, 1518, largest legal byte count in a header; larger counts mark the header as corrupt.

Ports:
clk  in  1  MAC Tx clock (156.25 MHz)
reset_n  in  1  asynchronous active-low reset
tx_data  out  64  MAC Tx data, byte 0 in bits [7:0]
tx_data_valid  out  8  per-byte valid; contiguous from bit 0
tx_start  out  1  start-of-frame request to MAC
tx_ack  in  1  MAC accepted first word; data must then flow every cycle
tx_underrun  out  1  tied 0, never asserted
rd_addr  out  9  TX buffer read address
rd_data  in  64  TX buffer read data, registered, 1-cycle latency
commited_wr_address  in  10  host-side extended write pointer (250 MHz domain); next free header slot
commited_rd_address  out  10  extended address of the next unread header
frames_sent_counter  out  32  frames fully handed to MAC
bad_desc_counter  out  32  headers dropped as corrupt

Behaviour:
- Reset values: tx_data 0, tx_data_valid 0, tx_start 0, tx_underrun 0, rd_addr 0, commited_rd_address 0, both counters 0, state IDLE. Reset mid-frame aborts immediately. No recovery of a partially sent frame.
- Pointer sync: sample commited_wr_address into reg0, then reg1. Load the filtered copy wr_sync only when reg0 == reg1, which suppresses transitory multi-bit values. Reset value of all three is 0.
- Address arithmetic: 10-bit extended, modulo 1024. rd_addr = rd_ptr[8:0]. Buffer empty when rd_ptr == wr_sync.
- Header word: bits [63:32] hold len in bytes; bits [31:0] are ignored. Data words = ceil(len/8). The next header is at hdr + 1 + ceil(len/8).
- FSM:
  - IDLE: drive outputs 0. If not empty, present rd_addr = hdr and go to HDR.
  - HDR: wait 1 cycle for read latency, then latch len.
    - len == 0: advance the pointer by 1, update commited_rd_address, return to IDLE. No counter change.
    - len > MAX_FRAME_BYTES: set rd_ptr and commited_rd_address to wr_sync (flush), increment bad_desc_counter, go to IDLE.
    - Otherwise: fetch data word 1 and go to START.
  - START: tx_start = 1, tx_data = word 1, tx_data_valid = mask of word 1. Hold all of these until tx_ack, then deassert tx_start. Prefetch word 2 so it is presented in the cycle after ack. Single-word frame: go to COMMIT on ack; otherwise go to DATA.
  - DATA: present one new word every cycle with no gaps. Intermediate words use valid 8'hFF. After the last word is presented, go to COMMIT.
  - COMMIT: tx_data_valid = 0 for one cycle. commited_rd_address <= next header address. Increment frames_sent_counter. Go to IDLE.
- Last-word mask: r = len mod 8. r == 0 gives 8'hFF; otherwise (1<<r)-1. Example: len 60 gives last mask 8'h0F.
- Minimum gap between frames: IDLE + HDR gives at least 2 idle cycles after COMMIT.
- Data words are only read when the frame is already committed by the host, so underrun cannot occur.
- Pointer wrap: 0x3FF + 1 = 0x000. Memory address wraps 511 to 0.
- wr_sync changing during a frame has no effect on the current frame.

Test Plan:
- Header len = 64 at hdr 0, 8 data words, commited_wr_address = 9 -> tx_start held until tx_ack. Then 8 consecutive words all with valid 8'hFF. commited_rd_address = 9, frames_sent_counter = 1.
- len = 61, tx_ack delayed 5 cycles -> tx_start and word 1 held stable for 5 cycles. 8 words sent; the last has valid 8'h1F.
- Header at extended 0x3FC, len = 40 -> reads at addresses 508–511 then 0–1. commited_rd_address = 0x002.
- Header len = 0 followed by a valid 8-byte frame -> the first header is skipped with no tx_start. One single-word frame is sent with valid 8'hFF and ack-to-commit.
- Header len = 2000 -> no tx_start; bad_desc_counter = 1; commited_rd_address equals the synced write pointer.
- reset_n low during DATA -> tx_data_valid = 0 in the same cycle and all pointers 0. After release, idle until commited_wr_address changes.
